// File: rtl/pcie_link_reset_ctrl.sv
// pcie_link_reset_ctrl
// Watches the hard IP LTSSM state and sequences the application reset:
// app_rstn is released only after the link has sat in L0 for a debounce
// window, is pulled low again on link loss, and a hard IP restart pulse is
// requested when training stalls outside L0 for too long.
// Retrain (recovery entries from L0) and restart events are counted.
//
// Optional build macro: PCIE_LINK_CTRL_LED_EN adds the board LED outputs
// (and the gen2_speed / lane_act inputs that feed them).
//
// FSM states
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   WAIT_L0   | link training; timeout timer running (frozen in compliance)
//   DEBOUNCE  | L0 seen, waiting for DEBOUNCE_CYC consecutive L0 cycles
//   LINK_UP   | link stable, application released
//   LINK_DOWN | link lost, application held in reset for HOLD_CYC cycles
//   RESTART   | hip_rst_req asserted for RST_PULSE cycles
//
// All timers are down-counters loaded with (length-1) on state entry; a
// state's timed exit is taken when the counter reads zero.

module pcie_link_reset_ctrl #(
   parameter int unsigned DEBOUNCE_CYC = 1024,
   parameter int unsigned TIMEOUT_CYC  = 2**24,
   parameter int unsigned HOLD_CYC     = 256,
   parameter int unsigned RST_PULSE    = 16,
   parameter int unsigned CNT_W        = 26
) (
   input  logic       pld_clk,
   input  logic       pcie_rstn,
   input  logic [4:0] ltssm,
`ifdef PCIE_LINK_CTRL_LED_EN
   input  logic       gen2_speed,
   input  logic [3:0] lane_act,
   output logic       L0_led,
   output logic       comp_led,
   output logic       gen2_led,
   output logic       alive_led,
   output logic [3:0] lane_active_led,
`endif
   output logic       app_rstn,
   output logic       link_up,
   output logic       hip_rst_req,
   output logic       compliance,
   output logic [7:0] retrain_cnt,
   output logic [3:0] restart_cnt,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      ST_WAIT_L0   = 3'd0,
      ST_DEBOUNCE  = 3'd1,
      ST_LINK_UP   = 3'd2,
      ST_LINK_DOWN = 3'd3,
      ST_RESTART   = 3'd4
   } state_t;

   localparam logic [4:0] LTSSM_L0     = 5'b01111;
   localparam logic [4:0] LTSSM_COMP   = 5'b00011;
   localparam logic [4:0] LTSSM_REC_LO = 5'b01100;
   localparam logic [4:0] LTSSM_REC_HI = 5'b01110;
   localparam logic [4:0] LTSSM_DOWN_HI = 5'b01011;

   localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(RST_PULSE - 1);

   logic             rst_meta_q;
   logic             rst_sync_n;
   logic [4:0]       ltssm_q;      // registered LTSSM code (ltssm_r)
   logic [4:0]       prev_q;       // previous ltssm_q, for recovery entry detect
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       retrain_q, retrain_d;
   logic [3:0]       restart_q, restart_d;
   logic             app_rstn_q;
   logic             hip_rst_req_q;
   logic             compliance_q;

   logic             is_l0;
   logic             is_comp;
   logic             is_recovery;
   logic             is_down;

   // Reset synchronizer: asserts immediately, releases two edges later.
   always_ff @(posedge pld_clk or negedge pcie_rstn) begin
      if (!pcie_rstn) begin
         rst_meta_q <= 1'b0;
         rst_sync_n <= 1'b0;
      end else begin
         rst_meta_q <= 1'b1;
         rst_sync_n <= rst_meta_q;
      end
   end

   // Capture the LTSSM code once; every decision uses the registered copy.
   always_ff @(posedge pld_clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         ltssm_q <= 5'b00000;
         prev_q  <= 5'b00000;
      end else begin
         ltssm_q <= ltssm;
         prev_q  <= ltssm_q;
      end
   end

   assign is_l0       = (ltssm_q == LTSSM_L0);
   assign is_comp     = (ltssm_q == LTSSM_COMP);
   assign is_recovery = (ltssm_q >= LTSSM_REC_LO) && (ltssm_q <= LTSSM_REC_HI);
   assign is_down     = (ltssm_q <= LTSSM_DOWN_HI);

   // Next-state, timer and event-counter logic.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      retrain_d = retrain_q;
      restart_d = restart_q;
      unique case (state_q)
         ST_WAIT_L0: begin
            if (is_l0) begin
               state_d = ST_DEBOUNCE;
               cnt_d   = DEB_LAST;
            end else if (is_comp) begin
               // compliance testing may last indefinitely; never time out
               cnt_d = cnt_q;
            end else if (cnt_q == '0) begin
               state_d = ST_RESTART;
               cnt_d   = PULSE_LAST;
               if (restart_q != 4'hF) restart_d = restart_q + 4'd1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_DEBOUNCE: begin
            if (!is_l0) begin
               state_d = ST_WAIT_L0;
               cnt_d   = TO_LAST;
            end else if (cnt_q == '0) begin
               state_d = ST_LINK_UP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_LINK_UP: begin
            if (is_down) begin
               state_d = ST_LINK_DOWN;
               cnt_d   = HOLD_LAST;
            end else if (is_recovery && (prev_q == LTSSM_L0)) begin
               if (retrain_q != 8'hFF) retrain_d = retrain_q + 8'd1;
            end
         end
         ST_LINK_DOWN: begin
            if (cnt_q == '0) begin
               state_d = ST_WAIT_L0;
               cnt_d   = TO_LAST;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_RESTART: begin
            if (cnt_q == '0) begin
               state_d = ST_WAIT_L0;
               cnt_d   = TO_LAST;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = ST_WAIT_L0;
            cnt_d   = TO_LAST;
         end
      endcase
   end

   // FSM registers; outputs decoded from the next state so they move with state.
   always_ff @(posedge pld_clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         state_q       <= ST_WAIT_L0;
         cnt_q         <= TO_LAST;
         retrain_q     <= 8'd0;
         restart_q     <= 4'd0;
         app_rstn_q    <= 1'b0;
         hip_rst_req_q <= 1'b0;
         compliance_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         retrain_q     <= retrain_d;
         restart_q     <= restart_d;
         app_rstn_q    <= (state_d == ST_LINK_UP);
         hip_rst_req_q <= (state_d == ST_RESTART);
         compliance_q  <= is_comp;
      end
   end

   assign app_rstn    = app_rstn_q;
   assign link_up     = app_rstn_q;
   assign hip_rst_req = hip_rst_req_q;
   assign compliance  = compliance_q;
   assign retrain_cnt = retrain_q;
   assign restart_cnt = restart_q;
   assign state       = state_q;

`ifdef PCIE_LINK_CTRL_LED_EN
   logic [25:0] alive_q;
   logic        L0_led_q;
   logic        comp_led_q;
   logic        gen2_led_q;
   logic [3:0]  lane_led_q;

   // Board LEDs are active-low; alive_led blinks from a free-running counter.
   always_ff @(posedge pld_clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         alive_q    <= 26'd0;
         L0_led_q   <= 1'b0;
         comp_led_q <= 1'b0;
         gen2_led_q <= 1'b0;
         lane_led_q <= 4'd0;
      end else begin
         alive_q    <= alive_q + 26'd1;
         L0_led_q   <= ~is_l0;
         comp_led_q <= ~is_comp;
         gen2_led_q <= ~gen2_speed;
         lane_led_q <= ~lane_act;
      end
   end

   assign alive_led       = alive_q[25];
   assign L0_led          = L0_led_q;
   assign comp_led        = comp_led_q;
   assign gen2_led        = gen2_led_q;
   assign lane_active_led = lane_led_q;
`endif

endmodule

// File: doc/pcie_link_reset_ctrl.md
# pcie_link_reset_ctrl

Link-state monitor and application reset sequencer for the chaining DMA top level. Sits between the PCIe hard IP `test_out_icm` LTSSM status and the application logic. Releases `app_rstn` only after the link has been stable in L0. Counts retrains, and requests a hard IP restart when link training times out.

## Interface
- `DEBOUNCE_CYC`, default 1024: consecutive L0 cycles required before release.
- `TIMEOUT_CYC`, default 2^24: WAIT_L0 cycles before restart.
- `HOLD_CYC`, default 256: cycles that `app_rstn` stays low after link loss.
- `RST_PULSE`, default 16: width of `hip_rst_req`.
- `CNT_W`, default 26: internal counter width; must hold the largest of the above.

Ports:
- `pld_clk` in 1: single clock, same as core `pld_clk`.
- `pcie_rstn` in 1: reset, asynchronous assert, active-low.
- `ltssm` in 5: `test_out_icm[4:0]`.
- `gen2_speed` in 1: only with LED macro.
- `lane_act` in 4: `test_out_icm[8:5]`, only with LED macro.
- `app_rstn` out 1: application reset, active-low.
- `link_up` out 1: link is up.
- `hip_rst_req` out 1: restart pulse to hard IP.
- `compliance` out 1: `ltssm_r == 5'b00011`.
- `retrain_cnt` out 8: saturating recovery-entry count.
- `restart_cnt` out 4: saturating timeout-restart count.
- `state` out 3: FSM state, debug.
- LED outputs (`L0_led`, `comp_led`, `gen2_led`, `alive_led`, `lane_active_led[3:0]`): only with macro.

## Operation
- `pcie_rstn` passes through an internal 2-flop synchronizer (async clear, sync release), giving `rst_sync_n`. All logic is cleared by `rst_sync_n`.
- `ltssm` is registered once into `ltssm_r`; all decisions use `ltssm_r`. `prev_r` holds the previous `ltssm_r`.
- Codes:
  - L0 = 5'b01111
  - compliance = 5'b00011
  - recovery = 5'b01100..5'b01110
  - down = `ltssm_r <= 5'b01011`
- FSM states: WAIT_L0=0, DEBOUNCE=1, LINK_UP=2, LINK_DOWN=3, RESTART=4.
  - WAIT_L0: `cnt++` each cycle.
    - `ltssm_r==L0` → DEBOUNCE with `cnt=0`.
    - Compliance: `cnt` is frozen and no timeout is taken.
    - `cnt==TIMEOUT_CYC-1` → RESTART, `cnt=0`, `restart_cnt++` (saturates at 15).
  - DEBOUNCE:
    - `ltssm_r!=L0` → WAIT_L0 with `cnt=0`.
    - `cnt==DEBOUNCE_CYC-1` → LINK_UP.
  - LINK_UP:
    - down → LINK_DOWN with `cnt=0`.
    - Recovery with `prev_r==L0` → `retrain_cnt++` (saturates at 255) and stay.
    - Any other code (L0s/L1/recovery) → stay.
  - LINK_DOWN: `cnt==HOLD_CYC-1` → WAIT_L0 with `cnt=0`.
  - RESTART: `cnt==RST_PULSE-1` → WAIT_L0 with `cnt=0`.
- Outputs are registered and decoded from the next state, so they change on the same edge as `state`:
  - `app_rstn = link_up = (state==LINK_UP)`.
  - `hip_rst_req = (state==RESTART)`.
- Counters `retrain_cnt` and `restart_cnt` clear only on reset.

## Timing
- Reset values:
  - `state`=WAIT_L0
  - `app_rstn`=0, `link_up`=0, `hip_rst_req`=0, `compliance`=0
  - all counters 0
  - all LEDs 0
- After `pcie_rstn` rises, logic leaves reset at the 2nd `pld_clk` edge.
- `ltssm` to `ltssm_r` takes 1 cycle; `ltssm_r` to state/outputs takes 1 cycle.
- Link-up latency: `ltssm` first shows L0 before edge k → DEBOUNCE at edge k+1 → `link_up`/`app_rstn`=1 at edge k+1+DEBOUNCE_CYC (L0 held throughout).
- Link-loss latency: `ltssm` shows a down code before edge k → `app_rstn`=0 at edge k+1.
- A single non-L0 cycle in DEBOUNCE restarts the debounce from zero.
- `pcie_rstn` low in any state returns outputs to reset values immediately, asynchronously; counters also clear.

## Configuration
- `PCIE_LINK_CTRL_LED_EN` defined: adds `gen2_speed`, `lane_act` and the LED ports. LEDs are registered under `rst_sync_n`:
  - `alive_led` = bit 25 of a free-running 26-bit counter
  - `comp_led` = ~(`ltssm_r`==compliance)
  - `L0_led` = ~(`ltssm_r`==L0)
  - `gen2_led` = ~`gen2_speed`
  - `lane_active_led` = ~`lane_act`
- Undefined: those ports and their registers are absent; all other behaviour is identical.

## Test plan
Parameters for all scenarios: DEBOUNCE_CYC=8, TIMEOUT_CYC=64, HOLD_CYC=4, RST_PULSE=16.
- Release reset, drive `ltssm`=01111 from cycle 5 → `app_rstn`/`link_up` rise exactly 9 edges later; `retrain_cnt`=0.
- In DEBOUNCE, drive L0 for 6 cycles, 1 cycle of 01110, then L0 → no release until 8 further consecutive L0 cycles.
- Hold `ltssm`=00010 → `hip_rst_req` high for 16 cycles starting 64 cycles after WAIT_L0 entry; `restart_cnt`=1. Repeat 20 timeouts → `restart_cnt` saturates at 15.
- Hold `ltssm`=00011 for 200 cycles → `compliance`=1, no `hip_rst_req`. Then L0 → normal link-up.
- While linked up, apply 300 L0→01101→L0 excursions → `link_up` stays 1 and `retrain_cnt`=255. Then 00001 → `app_rstn`=0 next edge, WAIT_L0 after 4 cycles.
- Deassert `pcie_rstn` mid-LINK_UP → all outputs 0 asynchronously; re-release → outputs remain 0 until a fresh debounce completes.
